pipe_datapath_fwd: RTL and testbench

- Parametrised successor to the single-issue ID/EX/MEM/WB datapath.
- Accepts decoded instructions at the ID boundary and contains the register file, ID/EX, EX/MEM and MEM/WB registers, the ALU and the write-back mux.
- Adds operand forwarding, load-use stall generation, branch resolution with flush, and parametrised data width and register count.
- Sits between the decode/control unit and an external synchronous data memory.

---
 rtl/pipe_datapath_fwd.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_datapath_fwd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_datapath_fwd.sv
// ID/EX/MEM/WB datapath with register file, operand forwarding,
// load-use stall generation and branch resolution with flush.
module pipe_datapath_fwd #(
    parameter int WIDTH    = 32,
    parameter int RAW      = 5,
    parameter bit FORWARD  = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [RAW-1:0]   id_rs,
    input  logic [RAW-1:0]   id_rt,
    input  logic [RAW-1:0]   id_rd,
    input  logic [15:0]      id_imm,
    input  logic [2:0]       id_alu_op,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_dst,
    input  logic             id_alu_src,
    input  logic             id_branch,
    output logic             stall,
    output logic             flush,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic             dmem_we,
    output logic             dmem_re,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             wb_valid,
    output logic [RAW-1:0]   wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int NREG = 2 ** RAW;

    logic [WIDTH-1:0] rf_q [NREG];

    logic             ex_valid_q, ex_rw_q, ex_m2r_q, ex_mr_q, ex_mw_q;
    logic             ex_src_q, ex_br_q;
    logic [WIDTH-1:0] ex_pc_q, ex_a_q, ex_b_q;
    logic [RAW-1:0]   ex_rs_q, ex_rt_q, ex_dest_q;
    logic [15:0]      ex_imm_q;
    logic [2:0]       ex_op_q;

    logic             mem_valid_q, mem_rw_q, mem_m2r_q, mem_mr_q, mem_mw_q;
    logic [WIDTH-1:0] mem_alu_q, mem_wd_q;
    logic [RAW-1:0]   mem_dest_q;

    logic             wb_valid_q, wb_rw_q, wb_m2r_q;
    logic [WIDTH-1:0] wb_alu_q, wb_ld_q;
    logic [RAW-1:0]   wb_dest_q;

    logic [RAW-1:0]   id_dest;
    logic             id_uses_rt, id_take;
    logic [WIDTH-1:0] rs_val, rt_val;
    logic [WIDTH-1:0] op_a, op_b, alu_b, alu_y, imm_ext;
    logic             hit_ex_ld, hit_ex, hit_mem;

    function automatic logic nz(input logic [RAW-1:0] d);
        return !ZERO_REG || (d != '0);
    endfunction

    // True when destination d of a live stage is a source of the ID instruction
    function automatic logic id_hit(input logic v, input logic [RAW-1:0] d);
        return v && nz(d) && (d == id_rs || (id_uses_rt && d == id_rt));
    endfunction

    assign id_dest    = id_reg_dst ? id_rd : id_rt;
    assign id_uses_rt = !id_alu_src || id_mem_write || id_branch;

    always_comb begin
        rs_val = rf_q[id_rs];
        rt_val = rf_q[id_rt];
        if (ZERO_REG && id_rs == '0) rs_val = '0;
        if (ZERO_REG && id_rt == '0) rt_val = '0;
        if (wb_valid && wb_addr == id_rs) rs_val = wb_data;
        if (wb_valid && wb_addr == id_rt) rt_val = wb_data;
    end

    always_comb begin
        op_a = ex_a_q;
        op_b = ex_b_q;
        if (FORWARD) begin
            if (wb_valid && wb_addr == ex_rs_q) op_a = wb_data;
            if (wb_valid && wb_addr == ex_rt_q) op_b = wb_data;
            if (mem_valid_q && mem_rw_q && !mem_mr_q && nz(mem_dest_q)) begin
                if (mem_dest_q == ex_rs_q) op_a = mem_alu_q;
                if (mem_dest_q == ex_rt_q) op_b = mem_alu_q;
            end
        end
    end

    assign imm_ext = WIDTH'($signed(ex_imm_q));
    assign alu_b   = ex_src_q ? imm_ext : op_b;

    always_comb begin
        case (ex_op_q)
            3'b000:  alu_y = op_a & alu_b;
            3'b001:  alu_y = op_a | alu_b;
            3'b010:  alu_y = op_a + alu_b;
            3'b110:  alu_y = op_a - alu_b;
            3'b111:  alu_y = WIDTH'($signed(op_a) < $signed(alu_b));
            default: alu_y = '0;
        endcase
    end

    assign flush = ex_valid_q && ex_br_q && (op_a == op_b);
    assign branch_target = flush ? ex_pc_q + WIDTH'(4) + (imm_ext << 2) : '0;

    assign hit_ex_ld = id_hit(ex_valid_q && ex_mr_q, ex_dest_q);
    assign hit_ex    = id_hit(ex_valid_q && ex_rw_q, ex_dest_q);
    assign hit_mem   = id_hit(mem_valid_q && mem_rw_q, mem_dest_q);

    assign stall   = id_valid && !flush && (FORWARD ? hit_ex_ld : (hit_ex || hit_mem));
    assign id_take = id_valid && !stall && !flush;

    // Branches are stripped of register and memory side effects on entry to EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rw_q    <= 1'b0;
            ex_m2r_q   <= 1'b0;
            ex_mr_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_src_q   <= 1'b0;
            ex_br_q    <= 1'b0;
            ex_pc_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dest_q  <= '0;
            ex_imm_q   <= '0;
            ex_op_q    <= '0;
        end else begin
            ex_valid_q <= id_take;
            ex_rw_q    <= id_take && id_reg_write && !id_branch;
            ex_m2r_q   <= id_take && id_mem_to_reg && !id_branch;
            ex_mr_q    <= id_take && id_mem_read && !id_branch;
            ex_mw_q    <= id_take && id_mem_write && !id_branch;
            ex_br_q    <= id_take && id_branch;
            ex_src_q   <= id_alu_src;
            ex_pc_q    <= id_pc;
            ex_a_q     <= rs_val;
            ex_b_q     <= rt_val;
            ex_rs_q    <= id_rs;
            ex_rt_q    <= id_rt;
            ex_dest_q  <= id_dest;
            ex_imm_q   <= id_imm;
            ex_op_q    <= id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_m2r_q   <= 1'b0;
            mem_mr_q    <= 1'b0;
            mem_mw_q    <= 1'b0;
            mem_alu_q   <= '0;
            mem_wd_q    <= '0;
            mem_dest_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_m2r_q    <= 1'b0;
            wb_alu_q    <= '0;
            wb_ld_q     <= '0;
            wb_dest_q   <= '0;
        end else begin
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_m2r_q   <= ex_m2r_q;
            mem_mr_q    <= ex_mr_q;
            mem_mw_q    <= ex_mw_q;
            mem_alu_q   <= alu_y;
            mem_wd_q    <= op_b;
            mem_dest_q  <= ex_dest_q;
            wb_valid_q  <= mem_valid_q;
            wb_rw_q     <= mem_rw_q;
            wb_m2r_q    <= mem_m2r_q;
            wb_alu_q    <= mem_alu_q;
            wb_ld_q     <= dmem_rdata;
            wb_dest_q   <= mem_dest_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_valid) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign dmem_addr  = mem_alu_q;
    assign dmem_wdata = mem_wd_q;
    assign dmem_we    = mem_valid_q && mem_mw_q;
    assign dmem_re    = mem_valid_q && mem_mr_q;

    assign wb_valid = wb_valid_q && wb_rw_q && nz(wb_dest_q);
    assign wb_addr  = wb_dest_q;
    assign wb_data  = wb_m2r_q ? wb_ld_q : wb_alu_q;

endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Scoreboard bench: directed instruction streams into a forwarding and a
// stalling-only datapath, writebacks checked against hand-computed values.
module tb_pipe_datapath_fwd;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [2:0]  op;
        logic        rw, m2r, mr, mw, dst, src, br;
    } ins_t;

    localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110, SLT = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ins_t in0 = '0, in1 = '0;

    logic        stall0, flush0, we0, re0, wbv0;
    logic [31:0] tgt0, addr0, wd0, rd0, wbd0;
    logic [4:0]  wba0;
    logic        stall1, flush1, we1, re1, wbv1;
    logic [31:0] tgt1, addr1, wd1, wbd1;
    logic [31:0] rd1 = '0;
    logic [4:0]  wba1;

    logic [31:0] mem [16];
    logic        mem_clr = 1'b1;

    logic [36:0] q0 [$];
    logic [36:0] q1 [$];
    int total = 0, bad = 0, cyc = 0, nflush = 0;
    int wcyc [32];
    logic [31:0] last_tgt = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    pipe_datapath_fwd #(.WIDTH(32), .RAW(5), .FORWARD(1'b1), .ZERO_REG(1'b1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(in0.v), .id_pc(in0.pc),
        .id_rs(in0.rs), .id_rt(in0.rt), .id_rd(in0.rd), .id_imm(in0.imm),
        .id_alu_op(in0.op), .id_reg_write(in0.rw), .id_mem_to_reg(in0.m2r),
        .id_mem_read(in0.mr), .id_mem_write(in0.mw), .id_reg_dst(in0.dst),
        .id_alu_src(in0.src), .id_branch(in0.br), .stall(stall0), .flush(flush0),
        .branch_target(tgt0), .dmem_addr(addr0), .dmem_wdata(wd0), .dmem_we(we0),
        .dmem_re(re0), .dmem_rdata(rd0), .wb_valid(wbv0), .wb_addr(wba0),
        .wb_data(wbd0)
    );

    pipe_datapath_fwd #(.WIDTH(32), .RAW(5), .FORWARD(1'b0), .ZERO_REG(1'b1)) u_stl (
        .clk(clk), .rst_n(rst_n), .id_valid(in1.v), .id_pc(in1.pc),
        .id_rs(in1.rs), .id_rt(in1.rt), .id_rd(in1.rd), .id_imm(in1.imm),
        .id_alu_op(in1.op), .id_reg_write(in1.rw), .id_mem_to_reg(in1.m2r),
        .id_mem_read(in1.mr), .id_mem_write(in1.mw), .id_reg_dst(in1.dst),
        .id_alu_src(in1.src), .id_branch(in1.br), .stall(stall1), .flush(flush1),
        .branch_target(tgt1), .dmem_addr(addr1), .dmem_wdata(wd1), .dmem_we(we1),
        .dmem_re(re1), .dmem_rdata(rd1), .wb_valid(wbv1), .wb_addr(wba1),
        .wb_data(wbd1)
    );

    assign rd0 = mem[addr0[5:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 32'h1234;
        end else if (we0) begin
            mem[addr0[5:2]] <= wd0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic ins_t rr(input logic [2:0] op, input logic [4:0] d, s, t);
        ins_t x = '0;
        x.v = 1; x.op = op; x.rd = d; x.rs = s; x.rt = t; x.rw = 1; x.dst = 1;
        return x;
    endfunction

    function automatic ins_t ri(input logic [2:0] op, input logic [4:0] t, s, input logic [15:0] im);
        ins_t x = '0;
        x.v = 1; x.op = op; x.rt = t; x.rs = s; x.imm = im; x.rw = 1; x.src = 1;
        return x;
    endfunction

    function automatic ins_t lw(input logic [4:0] t, s, input logic [15:0] im);
        ins_t x = ri(ADD, t, s, im);
        x.m2r = 1; x.mr = 1;
        return x;
    endfunction

    function automatic ins_t sw(input logic [4:0] t, s, input logic [15:0] im);
        ins_t x = ri(ADD, t, s, im);
        x.rw = 0; x.mw = 1;
        return x;
    endfunction

    function automatic ins_t beq(input logic [4:0] s, t, input logic [15:0] im, input logic [31:0] pc);
        ins_t x = rr(SUB, 5'd0, s, t);
        x.rw = 0; x.br = 1; x.imm = im; x.pc = pc;
        return x;
    endfunction

    task automatic send(input bit w, input ins_t x, output int ns);
        ns = 0;
        @(negedge clk);
        if (w) in1 = x; else in0 = x;
        #1;
        while ((w ? stall1 : stall0) && ns < 20) begin
            ns++;
            @(negedge clk);
            #1;
        end
        if (ns >= 20) chk("stall_bound", 64'(ns), 64'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in0 = '0;
            in1 = '0;
        end
    endtask

    task automatic exp0(input logic [4:0] a, input logic [31:0] d);
        q0.push_back({a, d});
    endtask

    task automatic exp1(input logic [4:0] a, input logic [31:0] d);
        q1.push_back({a, d});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wbv0) begin
                if (q0.size() == 0) chk("wb0_unexpected", {27'd0, wba0, wbd0}, 64'd0);
                else chk("wb0", {27'd0, wba0, wbd0}, {27'd0, q0.pop_front()});
                wcyc[wba0] = cyc;
            end
            if (wbv1) begin
                if (q1.size() == 0) chk("wb1_unexpected", {27'd0, wba1, wbd1}, 64'd0);
                else chk("wb1", {27'd0, wba1, wbd1}, {27'd0, q1.pop_front()});
            end
            if (flush0) begin
                nflush++;
                last_tgt = tgt0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int ns, acc;
        for (int i = 0; i < 32; i++) wcyc[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        chk("reset_outs", {stall0, flush0, we0, re0, wbv0, tgt0, wbd0[26:0]}, 64'd0);
        chk("reset_mem_outs", {addr0, wd0}, 64'd0);
        rst_n = 1'b1;

        acc = 0;
        exp0(2, 5);        send(0, ri(ADD, 2, 0, 16'd5), ns); acc += ns;
        exp0(3, 7);        send(0, ri(ADD, 3, 0, 16'd7), ns); acc += ns;
        exp0(1, 12);       send(0, rr(ADD, 1, 2, 3), ns);     acc += ns;
        exp0(4, 24);       send(0, rr(ADD, 4, 1, 1), ns);     acc += ns;
        chk("fwd_no_stall", 64'(acc), 64'd0);

        exp0(5, 32'h1234); send(0, lw(5, 0, 16'd0), ns);
        exp0(6, 32'h2468); send(0, rr(ADD, 6, 5, 5), ns);
        chk("load_use_stall", 64'(ns), 64'd1);

        exp0(7, 12);       send(0, rr(SUB, 7, 4, 1), ns);
        exp0(8, 1);        send(0, rr(SLT, 8, 1, 4), ns);
        exp0(10, 32'hFFFF_FFFF); send(0, ri(ADD, 10, 0, 16'hFFFF), ns);
        exp0(9, 1);        send(0, rr(SLT, 9, 10, 0), ns);
        exp0(11, 5);       send(0, rr(AND_, 11, 2, 3), ns);
        exp0(12, 7);       send(0, rr(OR_, 12, 2, 3), ns);
        exp0(13, 0);       send(0, rr(3'b011, 13, 2, 3), ns);
        send(0, sw(4, 0, 16'd8), ns);
        exp0(14, 24);      send(0, lw(14, 0, 16'd8), ns);

        send(0, beq(1, 1, 16'd3, 32'h40), ns);
        send(0, ri(ADD, 15, 0, 16'd99), ns);
        send(0, rr(ADD, 0, 2, 3), ns);
        exp0(16, 0);       send(0, rr(ADD, 16, 0, 0), ns);
        idle(4);
        exp0(17, 5);       send(0, rr(ADD, 17, 0, 2), ns);
        idle(5);
        chk("flush_cycles", 64'(nflush), 64'd1);
        chk("branch_target", 64'(last_tgt), 64'h50);
        chk("store_mem2", 64'(mem[2]), 64'd24);
        chk("fwd_timing", 64'(wcyc[4] - wcyc[1]), 64'd1);
        chk("bubble_timing", 64'(wcyc[6] - wcyc[5]), 64'd2);

        send(0, sw(4, 0, 16'd12), ns);
        send(0, ri(ADD, 18, 0, 16'd77), ns);
        @(negedge clk);
        in0 = '0;
        chk("store_in_mem", {63'd0, we0}, 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("we_async_drop", {62'd0, we0, wbv0}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("store_killed", 64'(mem[3]), 64'd0);
        exp0(19, 0);       send(0, rr(ADD, 19, 4, 1), ns);
        exp0(20, 0);       send(0, rr(ADD, 20, 2, 3), ns);
        idle(6);
        chk("q0_drained", 64'(q0.size()), 64'd0);

        exp1(2, 5);        send(1, ri(ADD, 2, 0, 16'd5), ns);
        exp1(3, 7);        send(1, ri(ADD, 3, 0, 16'd7), ns);
        idle(3);
        exp1(1, 12);       send(1, rr(ADD, 1, 2, 3), ns);
        chk("nofwd_first", 64'(ns), 64'd0);
        exp1(4, 24);       send(1, rr(ADD, 4, 1, 1), ns);
        chk("nofwd_stall2", 64'(ns), 64'd2);
        idle(6);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
